// File: rtl/bc_ctrl_pkg.sv
// Shared encodings for the basic-computer instruction sequencer: bus sources,
// control-strobe bit positions, ALU functions, opcodes and timing steps.
package bc_ctrl_pkg;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_TR   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    typedef enum logic [1:0] {
        ALU_AND     = 2'd0,
        ALU_ADD     = 2'd1,
        ALU_PASS_DR = 2'd2
    } alu_op_e;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_ADD  = 3'd1,
        OP_LDA  = 3'd2,
        OP_STA  = 3'd3,
        OP_BUN  = 3'd4,
        OP_BSA  = 3'd5,
        OP_ISZ  = 3'd6,
        OP_RRIO = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } t_step_e;

    localparam int CTL_LD_AR  = 0;
    localparam int CTL_INR_AR = 1;
    localparam int CTL_LD_PC  = 2;
    localparam int CTL_INR_PC = 3;
    localparam int CTL_LD_DR  = 4;
    localparam int CTL_INR_DR = 5;
    localparam int CTL_LD_AC  = 6;
    localparam int CTL_LD_IR  = 7;
    localparam int CTL_LD_TR  = 8;
    localparam int CTL_MEM_WR = 9;
    localparam int CTRL_BITS  = 10;

    // Timing step on which each opcode finishes; RR/IO ends in its T3 wait.
    function automatic logic [2:0] last_step(input opcode_e op);
        case (op)
            OP_STA, OP_BUN:                 return T4;
            OP_AND, OP_ADD, OP_LDA, OP_BSA: return T5;
            OP_ISZ:                         return T6;
            default:                        return T3;
        endcase
    endfunction

endpackage

// File: rtl/bc_seq_counter.sv
// 3-bit sequence counter (SC) with synchronous reset, clear and increment,
// exposing both the binary step and its one-hot T[6:0] decode.
module bc_seq_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inr,
    output logic [2:0] sc,
    output logic [6:0] t
);

    logic [2:0] sc_q;
    logic [2:0] sc_d;

    always_comb begin
        sc_d = sc_q;
        if (clr) begin
            sc_d = 3'd0;
        end else if (inr) begin
            sc_d = sc_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q <= 3'd0;
        end else begin
            sc_q <= sc_d;
        end
    end

    // Code 7 is outside T0..T6 and decodes to no step at all.
    assign t  = 7'(8'd1 << sc_q);
    assign sc = sc_q;

endmodule

// File: rtl/bc_instr_sequencer.sv
// Instruction-cycle sequencer: latches opcode/I at T2 and decodes each timing
// step into bus select, control strobes, ALU function and handshake lines.
module bc_instr_sequencer
    import bc_ctrl_pkg::*;
#(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [15:0]       ir,
    input  logic              dr_zero,
    input  logic              rr_io_done,
    output logic [2:0]        bus_sel,
    output logic [CTRL_W-1:0] ctrl,
    output logic [1:0]        alu_op,
    output logic              rr_io_req,
    output logic              instr_done,
    output logic [2:0]        t_state
);

    opcode_e              op_q;
    opcode_e              op_d;
    logic                 i_q;
    logic                 i_d;
    logic [2:0]           sc;
    logic [6:0]           t;
    logic                 sc_clr;
    logic                 sc_inr;
    bus_sel_e             bus;
    alu_op_e              alu;
    logic [CTRL_BITS-1:0] ctrl_v;
    logic [2:0]           final_t;
    logic                 unused_ir;

    bc_seq_counter u_sc (
        .clk (clk),
        .rst (rst),
        .clr (sc_clr),
        .inr (sc_inr),
        .sc  (sc),
        .t   (t)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= OP_AND;
            i_q  <= 1'b0;
        end else begin
            op_q <= op_d;
            i_q  <= i_d;
        end
    end

    always_comb begin
        bus        = BUS_NONE;
        alu        = ALU_AND;
        ctrl_v     = '0;
        rr_io_req  = 1'b0;
        instr_done = 1'b0;
        sc_clr     = 1'b0;
        sc_inr     = 1'b0;
        op_d       = op_q;
        i_d        = i_q;
        final_t    = last_step(op_q);

        case (1'b1)
            t[0]: begin
                if (run) begin
                    bus               = BUS_PC;
                    ctrl_v[CTL_LD_AR] = 1'b1;
                    sc_inr            = 1'b1;
                end
            end
            t[1]: begin
                bus                = BUS_MEM;
                ctrl_v[CTL_LD_IR]  = 1'b1;
                ctrl_v[CTL_INR_PC] = 1'b1;
                sc_inr             = 1'b1;
            end
            t[2]: begin
                bus               = BUS_IR;
                ctrl_v[CTL_LD_AR] = 1'b1;
                op_d              = opcode_e'(ir[14:12]);
                i_d               = ir[15];
                sc_inr            = 1'b1;
            end
            t[3]: begin
                if (op_q == OP_RRIO) begin
                    rr_io_req = 1'b1;
                    if (rr_io_done) begin
                        instr_done = 1'b1;
                        sc_clr     = 1'b1;
                    end
                end else begin
                    if (i_q) begin
                        bus               = BUS_MEM;
                        ctrl_v[CTL_LD_AR] = 1'b1;
                    end
                    sc_inr = 1'b1;
                end
            end
            t[4]: begin
                case (op_q)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        bus               = BUS_MEM;
                        ctrl_v[CTL_LD_DR] = 1'b1;
                    end
                    OP_STA: begin
                        bus                = BUS_AC;
                        ctrl_v[CTL_MEM_WR] = 1'b1;
                    end
                    OP_BUN: begin
                        bus               = BUS_AR;
                        ctrl_v[CTL_LD_PC] = 1'b1;
                    end
                    OP_BSA: begin
                        bus                = BUS_PC;
                        ctrl_v[CTL_MEM_WR] = 1'b1;
                        ctrl_v[CTL_INR_AR] = 1'b1;
                    end
                    default: ;
                endcase
            end
            t[5]: begin
                case (op_q)
                    OP_AND: begin
                        ctrl_v[CTL_LD_AC] = 1'b1;
                        alu               = ALU_AND;
                    end
                    OP_ADD: begin
                        ctrl_v[CTL_LD_AC] = 1'b1;
                        alu               = ALU_ADD;
                    end
                    OP_LDA: begin
                        ctrl_v[CTL_LD_AC] = 1'b1;
                        alu               = ALU_PASS_DR;
                    end
                    OP_BSA: begin
                        bus               = BUS_AR;
                        ctrl_v[CTL_LD_PC] = 1'b1;
                    end
                    OP_ISZ: begin
                        ctrl_v[CTL_INR_DR] = 1'b1;
                    end
                    default: ;
                endcase
            end
            t[6]: begin
                if (op_q == OP_ISZ) begin
                    bus                = BUS_DR;
                    ctrl_v[CTL_MEM_WR] = 1'b1;
                    ctrl_v[CTL_INR_PC] = dr_zero;
                end
            end
            default: sc_clr = 1'b1;
        endcase

        // Execute steps past an opcode's final step are unreachable and simply recover to T0.
        if (t[4] || t[5] || t[6]) begin
            if (sc == final_t) begin
                instr_done = 1'b1;
                sc_clr     = 1'b1;
            end else if (sc > final_t) begin
                sc_clr = 1'b1;
            end else begin
                sc_inr = 1'b1;
            end
        end
    end

    assign bus_sel   = bus;
    assign alu_op    = alu;
    assign ctrl      = CTRL_W'(ctrl_v);
    assign t_state   = sc;
    assign unused_ir = ^ir[11:0];

endmodule

// File: tb/tb_bc_instr_sequencer.sv
// Randomized bench for bc_instr_sequencer: each instruction is expanded into a
// queue of expected per-cycle outputs from the instruction-cycle rules.
module tb_bc_instr_sequencer;
    import bc_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] ir;
    logic        dr_zero;
    logic        rr_io_done;
    logic [2:0]  bus_sel;
    logic [15:0] ctrl;
    logic [1:0]  alu_op;
    logic        rr_io_req;
    logic        instr_done;
    logic [2:0]  t_state;

    typedef struct {
        logic [2:0]  t;
        logic [2:0]  bus;
        logic [15:0] ctrl;
        logic [1:0]  alu;
        logic        req;
        logic        done;
        logic        rrd;
    } cyc_t;

    cyc_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    bc_instr_sequencer #(.CTRL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ir         (ir),
        .dr_zero    (dr_zero),
        .rr_io_done (rr_io_done),
        .bus_sel    (bus_sel),
        .ctrl       (ctrl),
        .alu_op     (alu_op),
        .rr_io_req  (rr_io_req),
        .instr_done (instr_done),
        .t_state    (t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic [15:0] bit_of(input int idx);
        logic [15:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic void add_cyc(input logic [2:0] t, input logic [2:0] bus, input logic [15:0] c,
                                    input logic [1:0] alu, input logic req, input logic done, input logic rrd);
        cyc_t e;
        e.t = t; e.bus = bus; e.ctrl = c; e.alu = alu; e.req = req; e.done = done; e.rrd = rrd;
        exp_q.push_back(e);
    endfunction

    task automatic compare_cycle(input cyc_t e);
        check_output("t_state", 16'(t_state), 16'(e.t));
        check_output("bus_sel", 16'(bus_sel), 16'(e.bus));
        check_output("ctrl", ctrl, e.ctrl);
        check_output("alu_op", 16'(alu_op), 16'(e.alu));
        check_output("rr_io_req", 16'(rr_io_req), 16'(e.req));
        check_output("instr_done", 16'(instr_done), 16'(e.done));
    endtask

    task automatic idle_cycles(input int n);
        cyc_t e;
        e.t = 3'd0; e.bus = 3'd0; e.ctrl = '0; e.alu = 2'd0; e.req = 1'b0; e.done = 1'b0; e.rrd = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst        = 1'b0;
            run        = 1'b0;
            ir         = 16'($urandom);
            dr_zero    = 1'($urandom);
            rr_io_done = 1'($urandom);
            #1;
            compare_cycle(e);
        end
    endtask

    // One instruction from T0; rst_at selects the cycle (0-based) in which rst is driven, -1 for none.
    task automatic apply_stimulus(input logic [15:0] ir_v, input int waits, input logic drz, input int rst_at);
        logic [2:0] op;
        cyc_t       e;
        int         n;
        op = ir_v[14:12];
        exp_q.delete();
        add_cyc(3'd0, 3'd2, bit_of(CTL_LD_AR), 2'd0, 1'b0, 1'b0, 1'b0);
        add_cyc(3'd1, 3'd7, bit_of(CTL_LD_IR) | bit_of(CTL_INR_PC), 2'd0, 1'b0, 1'b0, 1'b0);
        add_cyc(3'd2, 3'd5, bit_of(CTL_LD_AR), 2'd0, 1'b0, 1'b0, 1'b0);
        if (op == 3'd7) begin
            for (int w = 0; w <= waits; w++)
                add_cyc(3'd3, 3'd0, 16'd0, 2'd0, 1'b1, w == waits, w == waits);
        end else begin
            if (ir_v[15]) add_cyc(3'd3, 3'd7, bit_of(CTL_LD_AR), 2'd0, 1'b0, 1'b0, 1'b0);
            else          add_cyc(3'd3, 3'd0, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    add_cyc(3'd4, 3'd7, bit_of(CTL_LD_DR), 2'd0, 1'b0, 1'b0, 1'b0);
                    add_cyc(3'd5, 3'd0, bit_of(CTL_LD_AC), 2'(op), 1'b0, 1'b1, 1'b0);
                end
                3'd3: add_cyc(3'd4, 3'd4, bit_of(CTL_MEM_WR), 2'd0, 1'b0, 1'b1, 1'b0);
                3'd4: add_cyc(3'd4, 3'd1, bit_of(CTL_LD_PC), 2'd0, 1'b0, 1'b1, 1'b0);
                3'd5: begin
                    add_cyc(3'd4, 3'd2, bit_of(CTL_MEM_WR) | bit_of(CTL_INR_AR), 2'd0, 1'b0, 1'b0, 1'b0);
                    add_cyc(3'd5, 3'd1, bit_of(CTL_LD_PC), 2'd0, 1'b0, 1'b1, 1'b0);
                end
                default: begin
                    add_cyc(3'd4, 3'd7, bit_of(CTL_LD_DR), 2'd0, 1'b0, 1'b0, 1'b0);
                    add_cyc(3'd5, 3'd0, bit_of(CTL_INR_DR), 2'd0, 1'b0, 1'b0, 1'b0);
                    add_cyc(3'd6, 3'd3, bit_of(CTL_MEM_WR) | (drz ? bit_of(CTL_INR_PC) : 16'd0),
                            2'd0, 1'b0, 1'b1, 1'b0);
                end
            endcase
        end

        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            run        = (n == 0) ? 1'b1 : 1'($urandom);
            ir         = (e.t == 3'd2) ? ir_v : 16'($urandom);
            dr_zero    = (e.t == 3'd6) ? drz : 1'($urandom);
            rr_io_done = (op == 3'd7 && e.t == 3'd3) ? e.rrd : 1'($urandom);
            rst        = (n == rst_at);
            #1;
            compare_cycle(e);
            if (rst) exp_q.delete();
            n++;
        end
    endtask

    initial begin
        int op_r;
        rst = 1'b1; run = 1'b0; ir = '0; dr_zero = 1'b0; rr_io_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_cycles(4);

        apply_stimulus(16'h1123, 0, 1'b0, -1);
        apply_stimulus(16'hA050, 0, 1'b0, -1);
        apply_stimulus(16'h6123, 0, 1'b1, -1);
        apply_stimulus(16'h6123, 0, 1'b0, -1);
        apply_stimulus(16'h7800, 5, 1'b0, -1);
        apply_stimulus(16'h7800, 0, 1'b0, -1);
        apply_stimulus(16'h5200, 0, 1'b0, -1);
        apply_stimulus(16'h3000, 0, 1'b0, 4);
        idle_cycles(3);
        apply_stimulus(16'h4ABC, 0, 1'b0, -1);
        apply_stimulus(16'hD321, 0, 1'b0, 5);
        idle_cycles(2);

        for (int k = 0; k < 250; k++) begin
            op_r = $urandom_range(0, 7);
            apply_stimulus({1'($urandom), 3'(op_r), 12'($urandom)}, $urandom_range(0, 4),
                           1'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1);
            idle_cycles($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
